// File: rtl/ifetch_unit_pkg.sv
// Shared fetch-path definitions: widths, state encoding and the buffered entry format
// used by the fetch controller, its buffer and the decode handoff.
package ifetch_unit_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] INSN_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_KILL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            fault;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low bits of a redirect target are dropped.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response port plus the fetch-to-decode handoff.
// master = fetch unit side, slave = memory/decode side.
interface ifetch_unit_if;
  import ifetch_unit_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            imem_rsp_err;

  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [ILEN-1:0] if_instr;
  logic            if_fault;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output if_valid, if_pc, if_instr, if_fault,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  if_valid, if_pc, if_instr, if_fault,
    output if_ready
  );

endinterface

// File: rtl/ifetch_unit_fifo.sv
// Synchronous fetch buffer: registered storage, head visible one cycle after push,
// simultaneous push/pop keeps the count, flush empties it in one cycle.
module fetch_fifo
  import ifetch_unit_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  fetch_entry_t i_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic [CW-1:0] o_count,
  output logic         o_empty
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign o_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // NOTE: storage is not reset; the count/pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch controller: one outstanding word read, credit-limited against the fetch buffer,
// redirect flush with stale-response kill, and next-PC selection for the pc register.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter  int FIFO_DEPTH = 2,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_cur,
  output logic [XLEN-1:0] pc_next,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  ifetch_unit_if.master   bus
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_req_pc;

  logic            w_outstanding;
  logic            w_credit;
  logic            w_req_valid;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_if_valid;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;

  // A request is only issued when its response is guaranteed a buffer slot.
  assign w_outstanding = (r_state != FETCH_REQ);
  assign w_credit      = (r_state == FETCH_REQ) &&
                         ((w_count + CW'(w_outstanding)) < CW'(FIFO_DEPTH));
  assign w_req_valid   = !reset && w_credit && !redirect_valid;
  assign w_accept      = w_req_valid && bus.imem_req_ready;

  assign w_push        = (r_state == FETCH_WAIT) && bus.imem_rsp_valid && !redirect_valid;
  assign w_if_valid    = !w_empty && !redirect_valid;
  assign w_pop         = w_if_valid && bus.if_ready;

  assign w_push_entry.pc    = r_req_pc;
  assign w_push_entry.instr = bus.imem_rsp_data;
  assign w_push_entry.fault = bus.imem_rsp_err;

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = pc_cur;
  assign bus.if_valid       = w_if_valid;
  assign bus.if_pc          = w_head.pc;
  assign bus.if_instr       = w_head.instr;
  assign bus.if_fault       = w_head.fault;

  // NOTE: always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    pc_next = pc_cur;
    if (reset) begin
      pc_next = pc_cur;
    end else if (redirect_valid) begin
      pc_next = align_word(redirect_target);
    end else if (w_accept) begin
      pc_next = pc_cur + XLEN'(4);
    end
  end

  // WAIT/KILL both leave on the response; KILL only differs in that it is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= FETCH_REQ;
      r_req_pc <= '0;
    end else begin
      case (r_state)
        FETCH_REQ: begin
          if (w_accept) begin
            r_req_pc <= pc_cur;
            r_state  <= FETCH_WAIT;
          end
        end
        FETCH_WAIT, FETCH_KILL: begin
          if (bus.imem_rsp_valid)   r_state <= FETCH_REQ;
          else if (redirect_valid)  r_state <= FETCH_KILL;
        end
        default: r_state <= FETCH_REQ;
      endcase
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit: a memory model, a pc register model and a program-order
// scoreboard; a separate monitor pops expected entries whenever decode accepts one.
module tb_ifetch_unit;
  import ifetch_unit_pkg::*;

  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [XLEN-1:0] pc_cur = '0;
  logic [XLEN-1:0] pc_next;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_target = '0;

  ifetch_unit_if bus();

  ifetch_unit #(.FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_cur          (pc_cur),
    .pc_next         (pc_next),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int delivered = 0;

  // Scoreboard: entries the DUT must hold/deliver, oldest first.
  fetch_entry_t    exp_q[$];
  bit              pushed_now;
  logic [XLEN-1:0] exp_next_pc;
  logic [XLEN-1:0] pc_q;

  // Memory model: the single in-flight request.
  bit              pend;
  bit              stale;
  logic [XLEN-1:0] pend_addr;
  logic [ILEN-1:0] pend_data;
  logic            pend_err;
  int              pend_cnt;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_reset(input logic [XLEN-1:0] start);
    reset                = 1'b1;
    pc_cur               = start;
    redirect_valid       = 1'b0;
    redirect_target      = '0;
    bus.imem_req_ready   = 1'b0;
    bus.imem_rsp_valid   = 1'b0;
    bus.imem_rsp_data    = '0;
    bus.imem_rsp_err     = 1'b0;
    bus.if_ready         = 1'b0;
    exp_q.delete();
    pushed_now  = 0;
    pend        = 0;
    stale       = 0;
    pend_cnt    = 0;
    exp_next_pc = start;
    pc_q        = start;
    repeat (2) @(negedge clk);
    #1;
    check("rst_if_valid", bus.if_valid, 1'b0);
    check("rst_req_valid", bus.imem_req_valid, 1'b0);
    check("rst_pc_next", pc_next, start);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock of stimulus plus the reference model's view of that cycle.
  task automatic cycle(input int p_ready, input int p_ifr, input int p_redir, input int lat_max);
    logic            exp_req;
    logic            accept;
    logic [XLEN-1:0] exp_pc;
    fetch_entry_t    ent;
    @(negedge clk);
    pc_cur          = pc_q;
    redirect_valid  = ($urandom_range(0, 99) < p_redir);
    redirect_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : 32'($urandom_range(0, 1023));
    bus.imem_req_ready = ($urandom_range(0, 99) < p_ready);
    bus.if_ready       = ($urandom_range(0, 99) < p_ifr);
    if (pend && pend_cnt == 0) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = pend_data;
      bus.imem_rsp_err   = pend_err;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
      bus.imem_rsp_err   = 1'($urandom_range(0, 1));
      if (pend) pend_cnt--;
    end
    #1;
    exp_req = !redirect_valid && !pend && (exp_q.size() < DEPTH);
    check("req_valid", bus.imem_req_valid, exp_req);
    if (bus.imem_req_valid) check("req_addr", bus.imem_req_addr, pc_cur);
    accept = bus.imem_req_valid && bus.imem_req_ready;
    if (redirect_valid)  exp_pc = {redirect_target[XLEN-1:2], 2'b00};
    else if (accept)     exp_pc = pc_cur + 32'd4;
    else                 exp_pc = pc_cur;
    check("pc_next", pc_next, exp_pc);
    pushed_now = 0;
    if (bus.imem_rsp_valid) begin
      if (!redirect_valid && !stale) begin
        ent.pc    = pend_addr;
        ent.instr = pend_data;
        ent.fault = pend_err;
        exp_q.push_back(ent);
        pushed_now = 1;
      end
      pend = 0;
    end
    if (redirect_valid) begin
      exp_q.delete();
      pushed_now  = 0;
      stale       = pend;
      exp_next_pc = {redirect_target[XLEN-1:2], 2'b00};
    end
    if (accept) begin
      pend      = 1;
      stale     = 0;
      pend_addr = pc_cur;
      pend_data = $urandom;
      pend_err  = ($urandom_range(0, 7) == 0);
      pend_cnt  = $urandom_range(0, lat_max - 1);
    end
    pc_q = pc_next;
  endtask

  task automatic run_phase(input logic [XLEN-1:0] start, input int n, input int p_ready,
                           input int p_ifr, input int p_redir, input int lat_max);
    int d0;
    apply_reset(start);
    d0 = delivered;
    repeat (n) cycle(p_ready, p_ifr, p_redir, lat_max);
    checks++;
    if (delivered == d0) begin
      failures++;
      $display("FAIL progress: delivered=%0d required>0 (start=0x%08h)", delivered - d0, start);
    end
  endtask

  // Reset asserted between edges while a request is outstanding and the buffer is non-empty.
  task automatic async_reset_test();
    int budget;
    bit hit;
    budget = 200;
    hit    = 0;
    apply_reset('0);
    while (budget > 0 && !hit) begin
      cycle(100, 0, 0, 3);
      hit = pend && (exp_q.size() > (pushed_now ? 1 : 0));
      budget--;
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL async_setup: actual=timeout required=WAIT with buffered entry");
    end else begin
      #2;
      check("pre_async_if_valid", bus.if_valid, 1'b1);
      reset = 1'b1;
      #1;
      check("async_if_valid", bus.if_valid, 1'b0);
      check("async_req_valid", bus.imem_req_valid, 1'b0);
      check("async_pc_next", pc_next, pc_cur);
    end
  endtask

  // Monitor: decoupled from stimulus, compares every delivered entry against the scoreboard.
  initial begin : monitor
    fetch_entry_t e;
    logic         exp_vld;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        exp_vld = (exp_q.size() > (pushed_now ? 1 : 0)) && !redirect_valid;
        check("if_valid", bus.if_valid, exp_vld);
        if (bus.if_valid && bus.if_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_empty: actual pc=0x%08h required=no entry", bus.if_pc);
          end else begin
            e = exp_q.pop_front();
            check("if_pc", bus.if_pc, e.pc);
            check("if_instr", bus.if_instr, e.instr);
            check("if_fault", bus.if_fault, e.fault);
            check("pc_order", bus.if_pc, exp_next_pc);
            exp_next_pc = exp_next_pc + 32'd4;
            delivered++;
          end
        end
      end
    end
  end

  initial begin : stimulus
    apply_reset(32'h0000_000A);
    run_phase(32'h0000_0000, 1500, 100, 100, 0, 1);
    run_phase(32'h0000_0000, 1500, 70, 15, 0, 3);
    run_phase(32'h0000_0000, 3000, 70, 70, 8, 3);
    run_phase(32'hFFFF_FFE0, 400, 100, 100, 0, 1);
    run_phase(32'hFFFF_FFF0, 1500, 60, 60, 5, 2);
    async_reset_test();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
